// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-SRAM arbiter: FSM encoding, default access length, byte lanes.
package mem_arbiter_pkg;

  localparam logic [1:0] stIdle = 2'd0;
  localparam logic [1:0] stData = 2'd1;
  localparam logic [1:0] stInst = 2'd2;
  localparam logic [1:0] stDone = 2'd3;

  localparam int waitCyclesDef = 1;

  localparam int selW = 4;
  localparam logic [selW-1:0] selAll = 4'b1111;

  function automatic logic [29:0] wordAddr(input logic [31:0] byteAddr);
    return byteAddr[31:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_fetch_buf.sv
// One-entry instruction buffer: valid bit, word tag and the instruction last fetched from SRAM.
module mem_arbiter_fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookupWord,
  output logic        hit,
  output logic [31:0] hitInst,
  input  logic        fillEn,
  input  logic [29:0] fillWord,
  input  logic [31:0] fillInst,
  input  logic        invEn,
  input  logic [29:0] invWord
);

  logic        valid;
  logic [29:0] tagQ;
  logic [31:0] instQ;

  // Fill and invalidate come from different FSM states, so they never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      tagQ  <= '0;
      instQ <= '0;
    end else if (fillEn) begin
      valid <= 1'b1;
      tagQ  <= fillWord;
      instQ <= fillInst;
    end else if (invEn && valid && (invWord == tagQ)) begin
      valid <= 1'b0;
    end
  end

  assign hit     = valid && (lookupWord == tagQ);
  assign hitInst = instQ;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one shared SRAM port, data first.
// Define MEM_ARBITER_FETCH_BUF_EN to add a one-entry fetch buffer that skips repeated fetches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = waitCyclesDef
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_ce,
  input  logic [31:0]     if_addr,
  output logic [31:0]     if_inst,
  input  logic            mem_ce,
  input  logic            mem_we,
  input  logic [selW-1:0] mem_sel,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  output logic [31:0]     mem_rdata,
  output logic            sram_ce,
  output logic            sram_we,
  output logic [selW-1:0] sram_sel,
  output logic [31:0]     sram_addr,
  output logic [31:0]     sram_wdata,
  input  logic [31:0]     sram_rdata,
  output logic            stallreq
);

  localparam logic [3:0] lastCnt = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  waitCnt;
  logic        ifCeQ;
  logic [31:0] ifAddrQ;
  logic        fetchHitQ;
  logic        lastCyc;
  logic        bufHit;
  logic [31:0] bufInst;
  logic        idleHit;

  assign lastCyc = (waitCnt == lastCnt);

`ifdef MEM_ARBITER_FETCH_BUF_EN
  mem_arbiter_fetch_buf uFetchBuf (
    .clk        (clk),
    .rst        (rst),
    .lookupWord (wordAddr(if_addr)),
    .hit        (bufHit),
    .hitInst    (bufInst),
    .fillEn     ((state == stInst) && lastCyc),
    .fillWord   (wordAddr(ifAddrQ)),
    .fillInst   (sram_rdata),
    .invEn      ((state == stData) && sram_we),
    .invWord    (wordAddr(sram_addr))
  );
`else
  assign bufHit  = 1'b0;
  assign bufInst = '0;
`endif

  // A store to the word being fetched must win over a stale buffered copy.
  assign idleHit = bufHit && !(mem_ce && mem_we && (wordAddr(mem_addr) == wordAddr(if_addr)));

  // The IDLE term must stall the requesting pipeline in the same cycle it asks.
  always_comb begin
    stallreq = 1'b0;
    if (rst) begin
      case (state)
        stIdle:         stallreq = mem_ce | (if_ce & ~idleHit);
        stData, stInst: stallreq = 1'b1;
        default:        stallreq = 1'b0;
      endcase
    end
  end

  // The data-side request is latched directly into the sram_* registers on leaving IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= stIdle;
      waitCnt    <= '0;
      ifCeQ      <= 1'b0;
      ifAddrQ    <= '0;
      fetchHitQ  <= 1'b0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_sel   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_inst    <= '0;
      mem_rdata  <= '0;
    end else begin
      case (state)
        stIdle: begin
          waitCnt   <= '0;
          ifCeQ     <= if_ce;
          ifAddrQ   <= if_addr;
          fetchHitQ <= idleHit;
          if (mem_ce) begin
            state      <= stData;
            sram_ce    <= 1'b1;
            sram_we    <= mem_we;
            sram_sel   <= mem_sel;
            sram_addr  <= mem_addr;
            sram_wdata <= mem_wdata;
          end else if (if_ce && idleHit) begin
            if_inst <= bufInst;
          end else if (if_ce) begin
            state     <= stInst;
            sram_ce   <= 1'b1;
            sram_we   <= 1'b0;
            sram_sel  <= selAll;
            sram_addr <= if_addr;
          end
        end
        stData: begin
          if (lastCyc) begin
            waitCnt <= '0;
            if (!sram_we) mem_rdata <= sram_rdata;
            if (ifCeQ && !fetchHitQ) begin
              state     <= stInst;
              sram_we   <= 1'b0;
              sram_sel  <= selAll;
              sram_addr <= ifAddrQ;
            end else begin
              state   <= stDone;
              sram_ce <= 1'b0;
              sram_we <= 1'b0;
              if (ifCeQ && fetchHitQ) if_inst <= bufInst;
            end
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        stInst: begin
          if (lastCyc) begin
            waitCnt <= '0;
            if_inst <= sram_rdata;
            state   <= stDone;
            sram_ce <= 1'b0;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        default: begin
          waitCnt <= '0;
          state   <= stIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural SRAM and a reference memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        sram_ce;
  logic        sram_we;
  logic [3:0]  sram_sel;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce      (if_ce),
    .if_addr    (if_addr),
    .if_inst    (if_inst),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_sel   (sram_sel),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .stallreq   (stallreq)
  );

  function automatic logic [31:0] initWord(input int i);
    case (i)
      4:       return 32'h24010001;
      32:      return 32'hDEADBEEF;
      33:      return 32'h11223344;
      default: return 32'hA5000000 | 32'(i);
    endcase
  endfunction

  logic [31:0] sramMem [0:63];
  logic        sramInit = 1'b0;

  always @(posedge clk) begin
    if (!sramInit) begin
      for (int i = 0; i < 64; i++) sramMem[i] <= initWord(i);
      sramInit <= 1'b1;
    end else if (sram_ce && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_sel[b]) sramMem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  assign sram_rdata = (sram_ce && !sram_we) ? sramMem[sram_addr[7:2]] : 32'h0;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } expT;

  logic [31:0] refMem [0:63];
  logic [31:0] expIfInst;
  logic [31:0] expRdata;
  expT         sbQ[$];
  int          total = 0;
  int          bad = 0;

  task automatic runAccess(input logic ic, input logic [31:0] ia, input logic mc, input logic mw,
                           input logic [3:0] ms, input logic [31:0] ma, input logic [31:0] md,
                           input logic glitch, output int stall, output int instCyc,
                           output int weCyc, output logic [31:0] firstAddr);
    logic        seen;
    logic        done;
    logic [31:0] w;
    expT         e;
    if (mc && mw) begin
      w = refMem[ma[7:2]];
      for (int b = 0; b < 4; b++) if (ms[b]) w[8*b +: 8] = md[8*b +: 8];
      refMem[ma[7:2]] = w;
    end else if (mc) begin
      expRdata = refMem[ma[7:2]];
    end
    if (ic) expIfInst = refMem[ia[7:2]];
    e.kind = 0; e.val = expIfInst; sbQ.push_back(e);
    e.kind = 1; e.val = expRdata;  sbQ.push_back(e);
    if_ce = ic; if_addr = ia; mem_ce = mc; mem_we = mw;
    mem_sel = ms; mem_addr = ma; mem_wdata = md;
    stall = 0; instCyc = 0; weCyc = 0; firstAddr = '0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (sram_ce && !seen) begin seen = 1'b1; firstAddr = sram_addr; end
      if (sram_ce && sram_we) weCyc++;
      if (ic && sram_ce && !sram_we && sram_addr == ia) instCyc++;
      if (!stallreq) begin done = 1'b1; break; end
      stall++;
      if (glitch && c == 1) begin
        if_addr = ia ^ 32'h4; mem_ce = 1'b1; mem_addr = 32'h8C;
      end
      @(negedge clk);
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout: stallreq still 1 after 64 cycles, want 0");
    end
    @(negedge clk);
    if_ce = 0; if_addr = '0; mem_ce = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    #1;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      total++;
      if (e.kind == 0) begin
        if (if_inst !== e.val) begin
          bad++; $display("FAIL if_inst: got %h want %h", if_inst, e.val);
        end
      end else begin
        if (mem_rdata !== e.val) begin
          bad++; $display("FAIL mem_rdata: got %h want %h", mem_rdata, e.val);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] act [8];
    string       nm [8];
    if_ce = 1; if_addr = 32'h10; mem_ce = 1; mem_we = 1; mem_sel = 4'hF;
    mem_addr = 32'h80; mem_wdata = 32'h55AA55AA;
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    act[0] = 32'(sram_ce);  nm[0] = "rst_sram_ce";
    act[1] = 32'(sram_we);  nm[1] = "rst_sram_we";
    act[2] = 32'(stallreq); nm[2] = "rst_stallreq";
    act[3] = 32'(sram_sel); nm[3] = "rst_sram_sel";
    act[4] = sram_addr;     nm[4] = "rst_sram_addr";
    act[5] = sram_wdata;    nm[5] = "rst_sram_wdata";
    act[6] = if_inst;       nm[6] = "rst_if_inst";
    act[7] = mem_rdata;     nm[7] = "rst_mem_rdata";
    for (int i = 0; i < 8; i++) begin
      total++;
      if (act[i] !== 32'h0) begin bad++; $display("FAIL %s: got %h want 0", nm[i], act[i]); end
    end
    if_ce = 0; if_addr = '0; mem_ce = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (stallreq !== 1'b0 || sram_ce !== 1'b0) begin
        bad++; $display("FAIL idle_quiet: got stallreq=%b sram_ce=%b want 0 0", stallreq, sram_ce);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_fetch();
    int st, ic, wc; logic [31:0] fa;
    runAccess(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 0, st, ic, wc, fa);
    total++; if (st !== 1 + W) begin bad++; $display("FAIL fetch_stall: got %0d want %0d", st, 1 + W); end
    total++; if (ic !== W) begin bad++; $display("FAIL fetch_inst_cycles: got %0d want %0d", ic, W); end
    total++; if (wc !== 0) begin bad++; $display("FAIL fetch_we_cycles: got %0d want 0", wc); end
  endtask

  task automatic test_load_fetch();
    int st, ic, wc; logic [31:0] fa;
    runAccess(1, 32'h14, 1, 0, 4'hF, 32'h80, 32'h0, 0, st, ic, wc, fa);
    total++; if (st !== 1 + 2*W) begin bad++; $display("FAIL ldf_stall: got %0d want %0d", st, 1 + 2*W); end
    total++; if (fa !== 32'h80) begin bad++; $display("FAIL ldf_order: got first addr %h want 00000080", fa); end
    total++; if (ic !== W) begin bad++; $display("FAIL ldf_inst_cycles: got %0d want %0d", ic, W); end
  endtask

  task automatic test_store();
    int st, ic, wc; logic [31:0] fa;
    runAccess(0, 32'h0, 1, 1, 4'b0011, 32'h84, 32'h0000ABCD, 0, st, ic, wc, fa);
    total++; if (wc !== W) begin bad++; $display("FAIL store_we_cycles: got %0d want %0d", wc, W); end
    total++; if (st !== 1 + W) begin bad++; $display("FAIL store_stall: got %0d want %0d", st, 1 + W); end
    runAccess(0, 32'h0, 1, 0, 4'hF, 32'h84, 32'h0, 0, st, ic, wc, fa);
    total++; if (st !== 1 + W) begin bad++; $display("FAIL reload_stall: got %0d want %0d", st, 1 + W); end
  endtask

  task automatic test_mid_change();
    int st, ic, wc; logic [31:0] fa;
    runAccess(1, 32'h18, 0, 0, 4'h0, 32'h0, 32'h0, 1, st, ic, wc, fa);
    total++; if (st !== 1 + W) begin bad++; $display("FAIL midchg_stall: got %0d want %0d", st, 1 + W); end
    total++; if (ic !== W) begin bad++; $display("FAIL midchg_inst_cycles: got %0d want %0d", ic, W); end
  endtask

  task automatic test_back_to_back();
    int st, ic, wc; logic [31:0] fa;
    runAccess(1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0, 0, st, ic, wc, fa);
    total++; if (st !== 1 + W) begin bad++; $display("FAIL b2b_first_stall: got %0d want %0d", st, 1 + W); end
    runAccess(1, 32'h34, 1, 0, 4'hF, 32'h90, 32'h0, 0, st, ic, wc, fa);
    total++; if (st !== 1 + 2*W) begin bad++; $display("FAIL b2b_second_stall: got %0d want %0d", st, 1 + 2*W); end
    total++; if (fa !== 32'h90) begin bad++; $display("FAIL b2b_order: got first addr %h want 00000090", fa); end
  endtask

  task automatic test_fetch_buf();
    int st, ic, wc; logic [31:0] fa;
    int expSt2, expIc2;
`ifdef MEM_ARBITER_FETCH_BUF_EN
    expSt2 = 0; expIc2 = 0;
`else
    expSt2 = 1 + W; expIc2 = W;
`endif
    runAccess(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 0, st, ic, wc, fa);
    total++; if (ic !== W) begin bad++; $display("FAIL buf_first_inst: got %0d want %0d", ic, W); end
    runAccess(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 0, st, ic, wc, fa);
    total++; if (ic !== expIc2) begin bad++; $display("FAIL buf_repeat_inst: got %0d want %0d", ic, expIc2); end
    total++; if (st !== expSt2) begin bad++; $display("FAIL buf_repeat_stall: got %0d want %0d", st, expSt2); end
    runAccess(0, 32'h0, 1, 1, 4'hF, 32'h20, 32'h12345678, 0, st, ic, wc, fa);
    total++; if (wc !== W) begin bad++; $display("FAIL buf_store_we: got %0d want %0d", wc, W); end
    runAccess(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0, 0, st, ic, wc, fa);
    total++; if (ic !== W) begin bad++; $display("FAIL buf_refetch_inst: got %0d want %0d", ic, W); end
  endtask

  task automatic test_reset_mid();
    int st, ic, wc; logic [31:0] fa;
    mem_ce = 1; mem_we = 1; mem_sel = 4'hF; mem_addr = 32'h88; mem_wdata = 32'hCAFEF00D;
    if_ce = 1; if_addr = 32'h3C;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sram_ce !== 1'b1 || sram_we !== 1'b1) begin
      bad++; $display("FAIL rstmid_active: got ce=%b we=%b want 1 1", sram_ce, sram_we);
    end
    rst = 0;
    #1;
    total++; if (sram_ce !== 1'b0) begin bad++; $display("FAIL rstmid_sram_ce: got %b want 0", sram_ce); end
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rstmid_sram_we: got %b want 0", sram_we); end
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL rstmid_stallreq: got %b want 0", stallreq); end
    if_ce = 0; if_addr = '0; mem_ce = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    @(negedge clk);
    rst = 1;
    expIfInst = '0; expRdata = '0;
    #1;
    total++;
    if (stallreq !== 1'b0 || sram_ce !== 1'b0) begin
      bad++; $display("FAIL rstmid_after: got stallreq=%b sram_ce=%b want 0 0", stallreq, sram_ce);
    end
    runAccess(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 0, st, ic, wc, fa);
    total++; if (st !== 1 + W) begin bad++; $display("FAIL rstmid_refetch_stall: got %0d want %0d", st, 1 + W); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
    expIfInst = '0; expRdata = '0;
    rst = 0;
    if_ce = 0; if_addr = '0; mem_ce = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    test_reset();
    test_idle();
    test_fetch();
    test_load_fetch();
    test_store();
    test_mid_change();
    test_back_to_back();
    test_fetch_buf();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, SRAM access length in cycles per access (legal 1..15).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
REQ-003 SHALL have ports if_ce in 1, if_addr in 32, if_inst out 32: fetch request enable, fetch byte address, fetched instruction.
REQ-004 SHALL have ports mem_ce in 1, mem_we in 1, mem_sel in 4, mem_addr in 32, mem_wdata in 32, mem_rdata out 32: data request, write enable, byte lanes, address, write data, read data.
REQ-005 SHALL have ports sram_ce out 1, sram_we out 1, sram_sel out 4, sram_addr out 32, sram_wdata out 32, sram_rdata in 32: single shared unified SRAM port.
REQ-006 SHALL have port stallreq out 1: stall request to the pipeline stall controller.

Function
REQ-007 SHALL implement the FSM IDLE, DATA, INST, DONE; state and all outputs SHALL be registered.
REQ-008 IDLE SHALL latch if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr and mem_wdata, then go to DATA if mem_ce=1, else INST if if_ce=1, else stay in IDLE.
REQ-009 Data SHALL have priority over fetch, because the data access belongs to the older instruction.
REQ-010 DATA SHALL drive sram_ce=1, sram_we=latched mem_we, sram_sel, sram_addr and sram_wdata from the latched values for exactly WAIT_CYCLES cycles.
- Reads SHALL capture sram_rdata into mem_rdata on the last cycle.
- DATA SHALL then go to INST if the latched if_ce=1, else DONE.
REQ-011 INST SHALL drive sram_ce=1, sram_we=0, sram_sel=4'b1111 and sram_addr=latched if_addr for WAIT_CYCLES cycles, capture sram_rdata into if_inst on the last cycle, then go to DONE.
REQ-012 DONE SHALL hold for one cycle with sram_ce=0 and stallreq=0, then go to IDLE.
REQ-013 stallreq SHALL be 1 in IDLE when (if_ce or mem_ce)=1, and in DATA and INST. It SHALL be 0 otherwise.
REQ-014 Latency for a fetch only: stallreq high for 1+WAIT_CYCLES cycles. For data plus fetch: 1+2*WAIT_CYCLES cycles.
REQ-015 The wait counter SHALL be 4 bits, clear on each state entry and never wrap past WAIT_CYCLES-1.
REQ-016 Request inputs SHALL be ignored outside IDLE; changes mid-access SHALL NOT affect the access in flight.
REQ-017 if_inst and mem_rdata SHALL hold their value until the next capture. A data write SHALL leave mem_rdata unchanged.
REQ-018 if_ce=0 and mem_ce=0 in IDLE SHALL produce no SRAM activity and stallreq=0.

Reset
REQ-019 rst=0 SHALL asynchronously force:
- state IDLE, counter 0
- sram_ce, sram_we, stallreq = 0
- sram_sel, sram_addr, sram_wdata, if_inst, mem_rdata = 0
REQ-020 Reset mid-access SHALL abort the access with no SRAM write completing after reset asserts.

Configuration
REQ-021 Macro MEM_ARBITER_FETCH_BUF_EN SHALL enable a one-entry fetch buffer holding a valid bit, a word address and an instruction.
REQ-022 With the macro defined, a fetch whose if_addr[31:2] matches a valid entry SHALL skip INST. A fetch-only hit SHALL then give stallreq=0 in IDLE, with the buffered word appearing on if_inst the next cycle.
REQ-023 With the macro defined, every INST capture SHALL refill the buffer. A DATA write to the buffered word address SHALL clear the valid bit.
REQ-024 Without the macro, no buffer SHALL exist and every fetch SHALL run INST.

Structure
REQ-025 A shared package SHALL hold:
- state encoding constants
- WAIT_CYCLES default
- sel width (4) and all-lanes constant 4'b1111
REQ-026 The fetch buffer SHALL be the sub-module mem_arbiter_fetch_buf, instantiated only under MEM_ARBITER_FETCH_BUF_EN.

Verification
REQ-027 Fetch only, if_addr=0x00000010, SRAM word 0x24010001, WAIT_CYCLES=1 -> stallreq high 2 cycles, if_inst=0x24010001 in DONE.
REQ-028 Load plus fetch: mem_addr=0x80, SRAM 0xDEADBEEF; if_addr=0x14 -> DATA before INST, stallreq high 3 cycles, mem_rdata=0xDEADBEEF.
REQ-029 Store: mem_we=1, mem_sel=4'b0011, mem_wdata=0x0000ABCD to 0x84 -> sram_we=1 exactly WAIT_CYCLES cycles, mem_rdata unchanged.
REQ-030 rst=0 during the second DATA cycle with WAIT_CYCLES=3 -> same-cycle sram_ce=0 and stallreq=0, state IDLE.
REQ-031 With MEM_ARBITER_FETCH_BUF_EN, fetch 0x20 twice -> second fetch has no INST state. Then store to 0x20 and refetch -> INST runs again.
